issueque_int: RTL and testbench

Four-entry integer issue queue that sits directly upstream of the issue unit and drives its `ready_int` request together with `opcode`, `rsdata`, `rtdata` and `rdtag`. It accepts dispatched integer instructions and holds them in age order. It snoops the CDB (`cdb_valid`, `cdb_tagout`, `cdb_out`) to capture missing source operands. Each cycle it presents the oldest entry whose operands are both ready, and retires that entry when the issue unit grants it with `issue_int`.

---
 rtl/issueque_int.sv | 159 +++++++++++++++
 tb/tb_issueque_int.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/issueque_int.sv
// issueque_int: four-entry (DEPTH) integer issue queue.
// Holds dispatched integer ops in age order (entry 0 oldest, compacting array).
// Snoops the CDB to capture missing operands, and presents the oldest entry
// whose operands are both ready to the issue unit. A grant removes that entry
// and shifts the younger entries down.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush               invalidate every entry on the next edge
//   dispatch_*          new instruction (opcode, rs/rt data+valid+tag, rdtag)
//   issueque_full       queue holds DEPTH entries; dispatch refused
//   cdb_valid/tagout/out  CDB broadcast used for operand wakeup
//   issueint_*          selected ready entry (all zero when none ready)
//   issue_int           grant from the issue unit for the presented entry
module issueque_int #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6,
    parameter int DATAW = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             dispatch_en,
    input  logic [OPW-1:0]   dispatch_opcode,
    input  logic [DATAW-1:0] dispatch_rsdata,
    input  logic [DATAW-1:0] dispatch_rtdata,
    input  logic             dispatch_rsvalid,
    input  logic             dispatch_rtvalid,
    input  logic [TAGW-1:0]  dispatch_rstag,
    input  logic [TAGW-1:0]  dispatch_rttag,
    input  logic [TAGW-1:0]  dispatch_rdtag,
    output logic             issueque_full,
    input  logic             cdb_valid,
    input  logic [TAGW-1:0]  cdb_tagout,
    input  logic [DATAW-1:0] cdb_out,
    output logic             issueint_ready,
    output logic [OPW-1:0]   issueint_opcode,
    output logic [DATAW-1:0] issueint_rsdata,
    output logic [DATAW-1:0] issueint_rtdata,
    output logic [TAGW-1:0]  issueint_rdtag,
    input  logic             issue_int
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);

    typedef struct packed {
        logic             v;
        logic [OPW-1:0]   op;
        logic [DATAW-1:0] rsd;
        logic [DATAW-1:0] rtd;
        logic             rsv;
        logic             rtv;
        logic [TAGW-1:0]  rst;
        logic [TAGW-1:0]  rtt;
        logic [TAGW-1:0]  rd;
    } ent_t;

    ent_t [DEPTH-1:0] r_q;
    logic [CW-1:0]    r_count;

    ent_t [DEPTH:0]   w_ext;      // r_q plus an always-empty slot on top for the shift
    ent_t [DEPTH-1:0] w_nq;
    ent_t             w_new;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_widx;
    logic [SW-1:0]    w_sel;
    logic             w_any;
    logic             w_grant;
    logic             w_disp;

    // Oldest ready entry; driven from registered state only.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_q[i].v && r_q[i].rsv && r_q[i].rtv) begin
                w_any = 1'b1;
                w_sel = SW'(i);
            end
        end
    end

    assign issueque_full   = (r_count == CW'(DEPTH));
    assign issueint_ready  = w_any;
    assign issueint_opcode = w_any ? r_q[w_sel].op  : '0;
    assign issueint_rsdata = w_any ? r_q[w_sel].rsd : '0;
    assign issueint_rtdata = w_any ? r_q[w_sel].rtd : '0;
    assign issueint_rdtag  = w_any ? r_q[w_sel].rd  : '0;

    assign w_grant = issue_int & w_any;
    // A full queue refuses dispatch even if a grant frees a slot this edge.
    assign w_disp  = dispatch_en & ~issueque_full;
    // A grant with a dispatch can only happen with count >= 1, so no underflow.
    assign w_widx  = r_count - CW'(w_grant);

    always_comb begin
        w_new = '{v:   1'b1,
                  op:  dispatch_opcode,
                  rsd: dispatch_rsdata,
                  rtd: dispatch_rtdata,
                  rsv: dispatch_rsvalid,
                  rtv: dispatch_rtvalid,
                  rst: dispatch_rstag,
                  rtt: dispatch_rttag,
                  rd:  dispatch_rdtag};
    end

    always_comb begin
        w_ext[DEPTH]       = '0;
        w_ext[DEPTH-1:0]   = r_q;
    end

    // Shift out the granted entry, drop in the dispatch, then snoop the CDB on
    // the post-shift image. Snooping the freshly written slot as well gives the
    // dispatch bypass for free.
    always_comb begin
        w_nq = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant && i >= int'(w_sel))
                w_nq[i] = w_ext[i+1];
            else
                w_nq[i] = w_ext[i];
            if (w_disp && CW'(i) == w_widx)
                w_nq[i] = w_new;
            if (cdb_valid && w_nq[i].v) begin
                if (!w_nq[i].rsv && w_nq[i].rst == cdb_tagout) begin
                    w_nq[i].rsd = cdb_out;
                    w_nq[i].rsv = 1'b1;
                end
                if (!w_nq[i].rtv && w_nq[i].rtt == cdb_tagout) begin
                    w_nq[i].rtd = cdb_out;
                    w_nq[i].rtv = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case ({w_disp, w_grant})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Data fields are cleared too so the presented outputs read zero when idle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_q     <= '0;
            r_count <= '0;
        end else begin
            r_q     <= w_nq;
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_issueque_int.sv
module tb_issueque_int;

    logic        clk;
    logic        reset, flush, dispatch_en;
    logic [3:0]  dispatch_opcode;
    logic [31:0] dispatch_rsdata, dispatch_rtdata;
    logic        dispatch_rsvalid, dispatch_rtvalid;
    logic [5:0]  dispatch_rstag, dispatch_rttag, dispatch_rdtag;
    logic        issueque_full;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        issueint_ready;
    logic [3:0]  issueint_opcode;
    logic [31:0] issueint_rsdata, issueint_rtdata;
    logic [5:0]  issueint_rdtag;
    logic        issue_int;

    int nchk = 0;
    int nerr = 0;

    issueque_int #(.DEPTH(4), .TAGW(6), .DATAW(32), .OPW(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rdtag(dispatch_rdtag), .issueque_full(issueque_full),
        .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
        .issueint_ready(issueint_ready), .issueint_opcode(issueint_opcode),
        .issueint_rsdata(issueint_rsdata), .issueint_rtdata(issueint_rtdata),
        .issueint_rdtag(issueint_rdtag), .issue_int(issue_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One record per cycle: inputs driven this cycle, and the outputs expected
    // during this cycle (they reflect state from previous edges only).
    typedef struct {
        logic        rst, fl, de, rsv, rtv, cv, iss, chk;
        logic [3:0]  op;
        logic [31:0] rs, rt, cdata;
        logic [5:0]  rstag, rttag, rd, ctag;
        logic        efull, erdy;
        logic [3:0]  eop;
        logic [31:0] ers, ert;
        logic [5:0]  erd;
    } vec_t;

    function automatic vec_t idle();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t dsp(vec_t vi, logic [3:0] op, logic [31:0] rs, logic rsv,
                                 logic [5:0] rstag, logic [31:0] rt, logic rtv,
                                 logic [5:0] rttag, logic [5:0] rd);
        vec_t v = vi;
        v.de = 1'b1; v.op = op; v.rs = rs; v.rsv = rsv; v.rstag = rstag;
        v.rt = rt; v.rtv = rtv; v.rttag = rttag; v.rd = rd;
        return v;
    endfunction

    function automatic vec_t cdb(vec_t vi, logic [5:0] tag, logic [31:0] data);
        vec_t v = vi;
        v.cv = 1'b1; v.ctag = tag; v.cdata = data;
        return v;
    endfunction

    function automatic vec_t iss(vec_t vi);
        vec_t v = vi;
        v.iss = 1'b1;
        return v;
    endfunction

    function automatic vec_t ex(vec_t vi, logic full, logic rdy, logic [3:0] op,
                                logic [31:0] rs, logic [31:0] rt, logic [5:0] rd);
        vec_t v = vi;
        v.chk = 1'b1; v.efull = full; v.erdy = rdy;
        v.eop = op; v.ers = rs; v.ert = rt; v.erd = rd;
        return v;
    endfunction

    function automatic vec_t ex0(vec_t vi, logic full);
        return ex(vi, full, 1'b0, 4'h0, 32'h0, 32'h0, 6'h0);
    endfunction

    task automatic run(input vec_t v, input string name);
        logic [75:0] got, exp;
        @(negedge clk);
        reset = v.rst; flush = v.fl; dispatch_en = v.de;
        dispatch_opcode = v.op; dispatch_rsdata = v.rs; dispatch_rtdata = v.rt;
        dispatch_rsvalid = v.rsv; dispatch_rtvalid = v.rtv;
        dispatch_rstag = v.rstag; dispatch_rttag = v.rttag; dispatch_rdtag = v.rd;
        cdb_valid = v.cv; cdb_tagout = v.ctag; cdb_out = v.cdata;
        issue_int = v.iss;
        #1;
        if (v.chk) begin
            got = {issueque_full, issueint_ready, issueint_opcode, issueint_rsdata,
                   issueint_rtdata, issueint_rdtag};
            exp = {v.efull, v.erdy, v.eop, v.ers, v.ert, v.erd};
            nchk++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL %s: got full=%b rdy=%b op=%h rs=%h rt=%h rd=%h, expected full=%b rdy=%b op=%h rs=%h rt=%h rd=%h",
                         name, got[75], got[74], got[73:70], got[69:38], got[37:6], got[5:0],
                         exp[75], exp[74], exp[73:70], exp[69:38], exp[37:6], exp[5:0]);
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t r;
        r = idle(); r.rst = 1'b1;
        // reset, then basic dispatch/issue
        tbl.push_back(r);                                                                        // 0
        tbl.push_back(ex0(idle(), 0));                                                           // 1 reset state
        tbl.push_back(ex0(dsp(idle(), 4'h2, 5, 1, 0, 7, 1, 0, 6'h11), 0));                        // 2
        tbl.push_back(ex(iss(idle()), 0, 1, 4'h2, 5, 7, 6'h11));                                 // 3
        tbl.push_back(ex0(idle(), 0));                                                           // 4
        // A waits on tag 09, B ready; wake A on the same edge B is granted
        tbl.push_back(ex0(dsp(idle(), 4'h3, 1, 1, 0, 0, 0, 6'h09, 6'h21), 0));                    // 5
        tbl.push_back(ex0(dsp(idle(), 4'h4, 2, 1, 0, 3, 1, 0, 6'h22), 0));                        // 6
        tbl.push_back(ex(cdb(iss(idle()), 6'h09, 32'hDEAD), 0, 1, 4'h4, 2, 3, 6'h22));           // 7
        tbl.push_back(ex(iss(idle()), 0, 1, 4'h3, 1, 32'hDEAD, 6'h21));                          // 8
        tbl.push_back(ex0(idle(), 0));                                                           // 9
        // dispatch bypass of a same-cycle broadcast
        tbl.push_back(ex0(cdb(dsp(idle(), 4'h5, 0, 0, 6'h03, 8, 1, 0, 6'h23), 6'h03, 32'h1234), 0)); // 10
        tbl.push_back(ex(iss(idle()), 0, 1, 4'h5, 32'h1234, 8, 6'h23));                          // 11
        tbl.push_back(ex0(idle(), 0));                                                           // 12
        // three entries; grant plus wakeup of entry 2 on the same edge
        tbl.push_back(ex0(dsp(idle(), 4'h6, 32'h10, 1, 0, 32'h11, 1, 0, 6'h30), 0));              // 13
        tbl.push_back(ex(dsp(idle(), 4'h7, 0, 0, 6'h0A, 32'h12, 1, 0, 6'h31), 0, 1, 4'h6, 32'h10, 32'h11, 6'h30)); // 14
        tbl.push_back(ex(dsp(idle(), 4'h8, 32'h13, 1, 0, 0, 0, 6'h0B, 6'h32), 0, 1, 4'h6, 32'h10, 32'h11, 6'h30)); // 15
        tbl.push_back(ex(cdb(iss(idle()), 6'h0B, 32'hBEEF), 0, 1, 4'h6, 32'h10, 32'h11, 6'h30)); // 16
        tbl.push_back(ex(idle(), 0, 1, 4'h8, 32'h13, 32'hBEEF, 6'h32));                          // 17
        tbl.push_back(ex(cdb(idle(), 6'h0A, 32'hCAFE), 0, 1, 4'h8, 32'h13, 32'hBEEF, 6'h32));    // 18
        tbl.push_back(ex(idle(), 0, 1, 4'h7, 32'hCAFE, 32'h12, 6'h31));                          // 19
        // flush with a same-cycle dispatch
        r = dsp(idle(), 4'h9, 1, 1, 0, 1, 1, 0, 6'h3A); r.fl = 1'b1;
        tbl.push_back(ex(r, 0, 1, 4'h7, 32'hCAFE, 32'h12, 6'h31));                               // 20
        // issue_int with nothing ready is ignored
        tbl.push_back(ex0(iss(idle()), 0));                                                      // 21
        tbl.push_back(ex0(dsp(idle(), 4'hA, 1, 1, 0, 2, 1, 0, 6'h33), 0));                        // 22
        tbl.push_back(ex(iss(idle()), 0, 1, 4'hA, 1, 2, 6'h33));                                 // 23
        tbl.push_back(ex0(idle(), 0));                                                           // 24

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i], $sformatf("vec%0d", i));

        // Fill to full; refused dispatches (alone and with a grant) never appear.
        for (int k = 1; k <= 4; k++) begin
            if (k == 1)
                run(ex0(dsp(idle(), 4'(k), k, 1, 0, k, 1, 0, 6'(k)), 0), $sformatf("fill%0d", k));
            else
                run(ex(dsp(idle(), 4'(k), k, 1, 0, k, 1, 0, 6'(k)), 0, 1, 4'h1, 1, 1, 6'h01),
                    $sformatf("fill%0d", k));
        end
        run(ex(dsp(idle(), 4'hF, 32'hF, 1, 0, 32'hF, 1, 0, 6'h3F), 1, 1, 4'h1, 1, 1, 6'h01), "full_refuse");
        run(ex(iss(dsp(idle(), 4'hE, 32'hE, 1, 0, 32'hE, 1, 0, 6'h3E)), 1, 1, 4'h1, 1, 1, 6'h01), "full_grant_refuse");
        run(ex(dsp(idle(), 4'hD, 32'hD, 1, 0, 32'hD, 1, 0, 6'h3D), 0, 1, 4'h2, 2, 2, 6'h02), "freed_accept");
        run(ex(iss(idle()), 1, 1, 4'h2, 2, 2, 6'h02), "drain2");
        run(ex(iss(idle()), 0, 1, 4'h3, 3, 3, 6'h03), "drain3");
        run(ex(iss(idle()), 0, 1, 4'h4, 4, 4, 6'h04), "drain4");
        run(ex(iss(idle()), 0, 1, 4'hD, 32'hD, 32'hD, 6'h3D), "drainD");
        run(ex0(idle(), 0), "drained");

        // Reset on the same edge as a grant discards everything.
        run(ex0(dsp(idle(), 4'h9, 9, 1, 0, 9, 1, 0, 6'h09), 0), "pre_reset");
        r = iss(idle()); r.rst = 1'b1;
        run(ex(r, 0, 1, 4'h9, 9, 9, 6'h09), "reset_grant");
        run(ex0(idle(), 0), "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
